// File: rtl/sfifo_pkg.sv
// Shared definitions for the SFIFO write arbiter: FSM encoding, stats counter
// width and the owner-index width helper.
package sfifo_pkg;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StBurst = 1'b1
  } arb_state_e;

  localparam int unsigned StatW = 16;

  // Bits needed to hold an owner index for n requesters.
  function automatic int unsigned owner_idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sfifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req scanning upward from
// last+1 with wrap-around.
module rr_pick #(
  parameter int unsigned Requesters = 4,
  parameter int unsigned IdxW       = 2
) (
  input  logic [Requesters-1:0] req,
  input  logic [IdxW-1:0]       last,
  output logic [Requesters-1:0] grant,
  output logic [IdxW-1:0]       idx,
  output logic                  any
);

  int unsigned      cand;
  logic [IdxW-1:0]  cand_idx;

  // Walk the ring starting just after the previous owner; first hit wins.
  always_comb begin
    grant    = '0;
    idx      = '0;
    any      = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 1; k <= Requesters; k++) begin
      cand     = (int'(last) + k) % Requesters;
      cand_idx = IdxW'(cand);
      if (!any && req[cand_idx]) begin
        any             = 1'b1;
        idx             = cand_idx;
        grant[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sfifo_wr_arbiter.sv
// Round-robin write arbiter sharing one SFIFO write port among Requesters
// producers, with bounded bursts of up to MaxBurst words per grant.
// Optional per-requester word counters and a stall counter are built when
// SFIFO_ARB_STATS_EN is defined.
module sfifo_wr_arbiter
  import sfifo_pkg::*;
#(
  parameter int unsigned Requesters = 4,
  parameter int unsigned Width      = 8,
  parameter int unsigned MaxBurst   = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [Requesters-1:0]        ReqValid,
  input  logic [Requesters*Width-1:0]  ReqData,
  output logic [Requesters-1:0]        ReqReady,
  input  logic                         FIFOFull,
  output logic                         FIFOWrReq,
  output logic [Width-1:0]             WRData,
  output logic [Requesters-1:0]        Grant
`ifdef SFIFO_ARB_STATS_EN
  ,
  output logic [Requesters*StatW-1:0]  WordCount,
  output logic [StatW-1:0]             StallCount
`endif
);

  localparam int unsigned IdxW = owner_idx_width(Requesters);
  localparam int unsigned CntW = $clog2(MaxBurst + 1);

  arb_state_e            state_q;
  logic [IdxW-1:0]       owner_q;
  logic [IdxW-1:0]       last_q;
  logic [Requesters-1:0] grant_q;
  logic [CntW-1:0]       count_q;

  logic                  owner_valid;
  logic                  xfer;
  logic                  burst_done;
  logic                  release_own;
  logic [Requesters-1:0] pick_req;
  logic [IdxW-1:0]       pick_last;
  logic [Requesters-1:0] pick_grant;
  logic [IdxW-1:0]       pick_idx;
  logic                  pick_any;

  // grant_q is one-hot on the owner while bursting, so this selects ReqValid[owner].
  assign owner_valid = |(ReqValid & grant_q);
  assign xfer        = (state_q == StBurst) && owner_valid && !FIFOFull;
  assign burst_done  = xfer && (count_q == CntW'(MaxBurst - 1));
  assign release_own = (state_q == StBurst) && (burst_done || !owner_valid);
  assign FIFOWrReq   = xfer;
  assign Grant       = grant_q;

  // On release the owner's valid still reflects the word just accepted, so it is
  // masked out; a lone producer re-arbitrates via IDLE and sees a one-cycle gap.
  assign pick_req  = (state_q == StBurst) ? (ReqValid & ~grant_q) : ReqValid;
  assign pick_last = (state_q == StBurst) ? owner_q : last_q;

  rr_pick #(
    .Requesters (Requesters),
    .IdxW       (IdxW)
  ) u_rr_pick (
    .req   (pick_req),
    .last  (pick_last),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Per-requester accept strobe and owner data mux.
  always_comb begin
    ReqReady = '0;
    WRData   = '0;
    for (int i = 0; i < Requesters; i++) begin
      if (owner_q == IdxW'(i)) begin
        ReqReady[i] = xfer;
        if (state_q == StBurst) WRData = ReqData[i*Width +: Width];
      end
    end
  end

  // Arbitration FSM: grant, owner, round-robin pointer and beat counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      owner_q <= '0;
      last_q  <= IdxW'(Requesters - 1);
      grant_q <= '0;
      count_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (pick_any) begin
            state_q <= StBurst;
            owner_q <= pick_idx;
            grant_q <= pick_grant;
            count_q <= '0;
          end
        end
        StBurst: begin
          if (release_own) begin
            last_q <= owner_q;
            if (pick_any) begin
              owner_q <= pick_idx;
              grant_q <= pick_grant;
              count_q <= '0;
            end else begin
              state_q <= StIdle;
              grant_q <= '0;
              count_q <= '0;
            end
          end else if (xfer) begin
            count_q <= count_q + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          grant_q <= '0;
        end
      endcase
    end
  end

`ifdef SFIFO_ARB_STATS_EN
  logic [StatW-1:0] word_cnt_q [Requesters];
  logic [StatW-1:0] stall_cnt_q;
  logic             stall;

  assign stall = (state_q == StBurst) && owner_valid && FIFOFull;

  // Saturating accepted-word counters per requester and owner-stalled counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < Requesters; i++) word_cnt_q[i] <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int i = 0; i < Requesters; i++) begin
        if (ReqReady[i] && (word_cnt_q[i] != '1)) word_cnt_q[i] <= word_cnt_q[i] + 1'b1;
      end
      if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  for (genvar g = 0; g < Requesters; g++) begin : g_word_count
    assign WordCount[g*StatW +: StatW] = word_cnt_q[g];
  end
  assign StallCount = stall_cnt_q;
`endif

endmodule

// File: tb/tb_sfifo_wr_arbiter.sv
// Directed table-driven bench for sfifo_wr_arbiter (Requesters=4, Width=8,
// MaxBurst=4). Each table row is one clock: inputs applied after the rising
// edge, outputs compared on the falling edge.
module tb_sfifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  ReqValid;
  logic [31:0] ReqData;
  logic [3:0]  ReqReady;
  logic        FIFOFull;
  logic        FIFOWrReq;
  logic [7:0]  WRData;
  logic [3:0]  Grant;
`ifdef SFIFO_ARB_STATS_EN
  logic [63:0] WordCount;
  logic [15:0] StallCount;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sfifo_wr_arbiter #(
    .Requesters (4),
    .Width      (8),
    .MaxBurst   (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ReqValid   (ReqValid),
    .ReqData    (ReqData),
    .ReqReady   (ReqReady),
    .FIFOFull   (FIFOFull),
    .FIFOWrReq  (FIFOWrReq),
    .WRData     (WRData),
    .Grant      (Grant)
`ifdef SFIFO_ARB_STATS_EN
    ,
    .WordCount  (WordCount),
    .StallCount (StallCount)
`endif
  );

  typedef struct {
    bit         rst;
    logic [3:0] valid;
    bit         full;
    logic [3:0] grant;
    bit         wrreq;
    logic [7:0] data;
    string      tag;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit rst, input logic [3:0] valid, input bit full,
                     input logic [3:0] grant, input bit wrreq, input logic [7:0] data,
                     input string tag);
    vec_t v;
    v.rst = rst; v.valid = valid; v.full = full; v.grant = grant;
    v.wrreq = wrreq; v.data = data; v.tag = tag;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Ends just after a rising edge with the DUT idle and the pointer at Requesters-1.
  task automatic do_reset();
    reset    = 1'b1;
    ReqValid = '0;
    FIFOFull = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_outputs(input string name, input logic [3:0] grant, input bit wrreq,
                               input logic [7:0] data);
    check({name, " Grant"}, 32'(Grant), 32'(grant));
    check({name, " FIFOWrReq"}, 32'(FIFOWrReq), 32'(wrreq));
    check({name, " ReqReady"}, 32'(ReqReady), 32'(wrreq ? grant : 4'b0000));
    check({name, " WRData"}, 32'(WRData), 32'(data));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ReqData  = {8'h13, 8'h12, 8'h11, 8'h10};
    ReqValid = 4'b1111;
    FIFOFull = 1'b0;
    reset    = 1'b1;

    // Reset state holds even with every requester valid.
    #3;
    check_outputs("reset", 4'b0000, 1'b0, 8'h00);
    @(posedge clk); #1;
    check_outputs("reset held", 4'b0000, 1'b0, 8'h00);

    // T1: single producer, 6 words, one bubble after the 4-word burst.
    add(1, 4'b0001, 0, 4'b0000, 0, 8'h00, "t1 idle");
    for (int i = 0; i < 4; i++) add(0, 4'b0001, 0, 4'b0001, 1, 8'h10, "t1 burst");
    add(0, 4'b0001, 0, 4'b0000, 0, 8'h00, "t1 bubble");
    for (int i = 0; i < 2; i++) add(0, 4'b0001, 0, 4'b0001, 1, 8'h10, "t1 tail");
    add(0, 4'b0000, 0, 4'b0001, 0, 8'h10, "t1 drop");
    add(0, 4'b0000, 0, 4'b0000, 0, 8'h00, "t1 released");

    // T2: all valid, rotation 0,1,2,3,0 with four beats each.
    add(1, 4'b1111, 0, 4'b0000, 0, 8'h00, "t2 idle");
    for (int b = 0; b < 5; b++) begin
      for (int w = 0; w < 4; w++) begin
        add(0, 4'b1111, 0, 4'(1 << (b % 4)), 1, 8'(8'h10 + (b % 4)), "t2 rotate");
      end
    end

    // T3: owner 1 stalled by Full for 5 cycles after 2 words.
    add(1, 4'b0010, 0, 4'b0000, 0, 8'h00, "t3 idle");
    for (int i = 0; i < 2; i++) add(0, 4'b0010, 0, 4'b0010, 1, 8'h11, "t3 pre");
    for (int i = 0; i < 5; i++) add(0, 4'b0010, 1, 4'b0010, 0, 8'h11, "t3 full");
    for (int i = 0; i < 2; i++) add(0, 4'b0010, 0, 4'b0010, 1, 8'h11, "t3 post");
    add(0, 4'b0010, 0, 4'b0000, 0, 8'h00, "t3 release");

    // T4: owner 2 gives up after one word, requester 3 takes over next cycle.
    add(1, 4'b0100, 0, 4'b0000, 0, 8'h00, "t4 idle");
    add(0, 4'b1100, 0, 4'b0100, 1, 8'h12, "t4 word");
    add(0, 4'b1000, 0, 4'b0100, 0, 8'h12, "t4 giveup");
    add(0, 4'b1000, 0, 4'b1000, 1, 8'h13, "t4 handoff");

    // T5 prefix: owner 0 burst, then owner 1 starts; reset lands during owner 1.
    add(1, 4'b0011, 0, 4'b0000, 0, 8'h00, "t5 idle");
    for (int i = 0; i < 4; i++) add(0, 4'b0011, 0, 4'b0001, 1, 8'h10, "t5 own0");
    add(0, 4'b0011, 0, 4'b0010, 1, 8'h11, "t5 own1");

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      ReqValid = tbl[i].valid;
      FIFOFull = tbl[i].full;
      @(negedge clk);
      check_outputs($sformatf("%s row%0d", tbl[i].tag, i), tbl[i].grant, tbl[i].wrreq,
                    tbl[i].data);
      if (FIFOWrReq && FIFOFull) check("wrreq while full", 32'(FIFOWrReq), 32'd0);
      @(posedge clk); #1;
    end

    // T5: asynchronous reset mid-burst (owner 1, one word done).
    ReqValid = 4'b0011;
    #2;
    reset = 1'b1;
    #1;
    check_outputs("t5 async reset", 4'b0000, 1'b0, 8'h00);
    @(posedge clk); #1;
    check_outputs("t5 reset held", 4'b0000, 1'b0, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check_outputs("t5 first after reset", 4'b0001, 1'b1, 8'h10);

`ifdef SFIFO_ARB_STATS_EN
    // T6: 40 cycles all valid, Full for 3 burst cycles; 39 burst cycles - 3 = 36 words.
    begin
      int pulses;
      int sum;
      pulses = 0;
      do_reset();
      ReqValid = 4'b1111;
      for (int c = 0; c < 40; c++) begin
        FIFOFull = (c >= 10 && c <= 12);
        @(negedge clk);
        if (FIFOWrReq) pulses++;
        @(posedge clk); #1;
      end
      ReqValid = 4'b0000;
      FIFOFull = 1'b0;
      sum = 0;
      for (int i = 0; i < 4; i++) sum += int'(WordCount[i*16 +: 16]);
      check("t6 wrreq pulses", 32'(pulses), 32'd36);
      check("t6 WordCount sum", 32'(sum), 32'd36);
      check("t6 StallCount", 32'(StallCount), 32'd3);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
